// File: rtl/core_bus_pkg.sv
// Shared types for the core bus arbiter slice.
//   bus_owner_t : which master owns a bus command or a pending read return
//   AVL_BE_FULL : byte enable driven for full-word instruction fetches
package core_bus_pkg;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_LSU = 1'b1
   } bus_owner_t;

   localparam logic [3:0] AVL_BE_FULL = 4'hF;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with show-ahead head output.
//   push/wdata  : write side, ignored when full
//   pop         : read side, ignored when empty
//   rdata       : current head entry
//   count       : number of stored entries (0..DEPTH)
//   full/empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/core_bus_arbiter.sv
// Shares the core Avalon-MM bus between instruction fetch (m0, read-only)
// and load/store (m1, read/write).
//   m0_*        : fetch master port
//   m1_*        : LSU master port
//   s_*         : bus master interface toward the slave
//   outstanding : reads accepted by the slave and not yet returned
//   err_rdv     : sticky, a return beat arrived with nothing outstanding
//
// Grant lock:
//   locked | meaning
//   -------+-------------------------------------------------------
//   0      | free arbitration each cycle
//   1      | command from owner stalled by waitrequest, grant held
module core_bus_arbiter
   import core_bus_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rest,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   output logic        m0_readdatavalid,
   input  logic [31:0] m1_address,
   input  logic [3:0]  m1_byteenable,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   output logic        m1_readdatavalid,
   output logic [31:0] s_address,
   output logic [3:0]  s_byteenable,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   input  logic        s_readdatavalid,
   output logic [3:0]  outstanding,
   output logic        err_rdv
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   logic       locked_q, locked_d;
   bus_owner_t owner_q, owner_d;
   logic [3:0] starve_q, starve_d;
   logic       err_q, err_d;

   logic          gnt_valid;
   bus_owner_t    gnt;
   logic          req0, req1, elig0, elig1, rd_ok, accept;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic [0:0]    fifo_head;
   logic [0:0]    gnt_bit;

   assign req0  = m0_read;
   assign req1  = m1_read | m1_write;
   // Eligibility uses the registered count only, so a return beat in the
   // same cycle never opens a combinational path into s_read.
   assign rd_ok = ~fifo_full;
   assign elig0 = m0_read & rd_ok;
   // Read+write together is treated as a write, which the count never blocks.
   assign elig1 = m1_write | (m1_read & rd_ok);

   // Grant is suppressed while reset is asserted so the bus goes idle at once.
   always_comb begin
      gnt_valid = 1'b0;
      gnt       = OWNER_IF;
      if (!rest) begin
         gnt_valid = 1'b0;
      end else if (locked_q) begin
         gnt_valid = 1'b1;
         gnt       = owner_q;
      end else if ((starve_q == 4'(STARVE_LIMIT)) && elig0) begin
         gnt_valid = 1'b1;
         gnt       = OWNER_IF;
      end else if (elig1) begin
         gnt_valid = 1'b1;
         gnt       = OWNER_LSU;
      end else if (elig0) begin
         gnt_valid = 1'b1;
         gnt       = OWNER_IF;
      end
   end

   always_comb begin
      s_address    = '0;
      s_byteenable = '0;
      s_read       = 1'b0;
      s_write      = 1'b0;
      s_writedata  = '0;
      if (gnt_valid) begin
         if (gnt == OWNER_IF) begin
            s_address    = m0_address;
            s_byteenable = AVL_BE_FULL;
            s_read       = 1'b1;
         end else begin
            s_address    = m1_address;
            s_byteenable = m1_byteenable;
            s_read       = m1_read & ~m1_write;
            s_write      = m1_write;
            s_writedata  = m1_writedata;
         end
      end
   end

   assign m0_waitrequest = (gnt_valid && gnt == OWNER_IF)  ? s_waitrequest : req0;
   assign m1_waitrequest = (gnt_valid && gnt == OWNER_LSU) ? s_waitrequest : req1;

   assign accept = gnt_valid & ~s_waitrequest;

   always_comb begin
      locked_d = locked_q;
      owner_d  = owner_q;
      if (gnt_valid && s_waitrequest) begin
         locked_d = 1'b1;
         owner_d  = gnt;
      end else if (accept) begin
         locked_d = 1'b0;
      end
   end

   // Saturates at the limit so a blocked fetch cannot let it run past the
   // compare value and lose its forced turn.
   always_comb begin
      starve_d = starve_q;
      if (!req0) begin
         starve_d = '0;
      end else if (accept && gnt == OWNER_IF) begin
         starve_d = '0;
      end else if (accept && gnt == OWNER_LSU && starve_q < 4'(STARVE_LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   assign err_d = err_q | (s_readdatavalid & fifo_empty);

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         locked_q <= 1'b0;
         owner_q  <= OWNER_IF;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         locked_q <= locked_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

   assign gnt_bit = gnt;

   fifo_sync #(
      .WIDTH (1),
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk   (clk),
      .rst_n (rest),
      .push  (s_read & ~s_waitrequest),
      .wdata (gnt_bit),
      .pop   (s_readdatavalid),
      .rdata (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & ~fifo_head[0];
   assign m1_readdatavalid = s_readdatavalid & ~fifo_empty &  fifo_head[0];
   assign outstanding      = 4'(fifo_count);
   assign err_rdv          = err_q;

endmodule
